// File: rtl/clint_timer_pkg.sv
// rtl/clint_timer_pkg.sv - shared CLINT address window, register offsets and helpers
package clint_timer_pkg;

    localparam logic [31:0] clint_base_addr = 32'h0200_0000;
    localparam logic [31:0] clint_top_addr  = 32'h0200_C000;

    // Half-period of the RTC in core clocks minus one
    localparam int unsigned clk_divider_rtc = 4;

    localparam logic [31:0] clint_msip_off     = 32'h0000_0000;
    localparam logic [31:0] clint_mtimecmp_off = 32'h0000_4000;
    localparam logic [31:0] clint_mtime_off    = 32'h0000_BFF8;

    typedef struct packed {
        logic        valid;
        logic [31:0] off;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } clint_req_t;

    // Replace the strobed bytes of old_word with the matching bytes of new_word
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_timer_if.sv
// rtl/clint_timer_if.sv - simple valid/ready memory bus into the CLINT
interface clint_timer_if;

    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/clint_timer_rtc_divider.sv
// rtl/clint_timer_rtc_divider.sv - RTC level generator producing a one-cycle mtime tick
module clint_timer_rtc_divider (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] clk_div,
    output logic        tick
);

    logic [15:0] cnt;
    logic        level;

    // Count 0..clk_div, toggling the RTC level on every wrap
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt   <= 16'd0;
            level <= 1'b0;
        end else if (cnt == clk_div) begin
            cnt   <= 16'd0;
            level <= ~level;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // The tick marks the cycle whose closing edge takes the level from 0 to 1
    assign tick = (cnt == clk_div) && !level;

endmodule

// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - core-local interruptor with mtime, mtimecmp and msip
module clint_timer
    import clint_timer_pkg::*;
#(
    parameter logic [31:0] clint_base = clint_base_addr,
    parameter int unsigned clk_div    = clk_divider_rtc
) (
    input  logic               clock,
    input  logic               reset,
    clint_timer_if.slave       bus,
    output logic               clint_msip,
    output logic               clint_mtip,
    output logic [63:0]        clint_mtime
);

    localparam logic [15:0] clk_div_w = 16'(clk_div);

    clint_req_t  req;
    logic        tick;
    logic        msip;
    logic        mtip;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        ready;
    logic [31:0] rdata;

    logic        wr;
    logic        sel_msip;
    logic        sel_cmp_lo;
    logic        sel_cmp_hi;
    logic        sel_mtime_lo;
    logic        sel_mtime_hi;
    logic [31:0] rdata_next;
    logic [63:0] mtime_inc;
    logic [63:0] mtime_next;

    clint_timer_rtc_divider u_rtc_divider (
        .clock   (clock),
        .reset   (reset),
        .clk_div (clk_div_w),
        .tick    (tick)
    );

    // Register the incoming request; it is served on the following edge
    always_ff @(posedge clock) begin
        if (reset) begin
            req <= '0;
        end else begin
            req.valid <= bus.mem_valid;
            req.off   <= bus.mem_addr - clint_base;
            req.wdata <= bus.mem_wdata;
            req.wstrb <= bus.mem_wstrb;
        end
    end

    // Decode the held request against the register map
    always_comb begin
        wr           = req.valid && (req.wstrb != 4'b0000);
        sel_msip     = (req.off == clint_msip_off);
        sel_cmp_lo   = (req.off == clint_mtimecmp_off);
        sel_cmp_hi   = (req.off == clint_mtimecmp_off + 32'd4);
        sel_mtime_lo = (req.off == clint_mtime_off);
        sel_mtime_hi = (req.off == clint_mtime_off + 32'd4);
    end

    // Read mux sees register values from before this cycle's tick or write
    always_comb begin
        rdata_next = 32'd0;
        if (sel_msip) begin
            rdata_next = {31'd0, msip};
        end else if (sel_cmp_lo) begin
            rdata_next = mtimecmp[31:0];
        end else if (sel_cmp_hi) begin
            rdata_next = mtimecmp[63:32];
        end else if (sel_mtime_lo) begin
            rdata_next = mtime[31:0];
        end else if (sel_mtime_hi) begin
            rdata_next = mtime[63:32];
        end
    end

    // Next mtime: written bytes win over the tick; a low-word write blocks the carry
    always_comb begin
        mtime_inc  = mtime + {63'd0, tick};
        mtime_next = mtime_inc;
        if (wr && sel_mtime_lo) begin
            mtime_next = {mtime[63:32], byte_merge(mtime_inc[31:0], req.wdata, req.wstrb)};
        end else if (wr && sel_mtime_hi) begin
            mtime_next[63:32] = byte_merge(mtime_inc[63:32], req.wdata, req.wstrb);
        end
    end

    // Response strobe and read data, one cycle after the request is sampled
    always_ff @(posedge clock) begin
        if (reset) begin
            ready <= 1'b0;
            rdata <= 32'd0;
        end else begin
            ready <= req.valid;
            if (req.valid) begin
                rdata <= rdata_next;
            end
        end
    end

    // Architectural registers and the lagging timer compare
    always_ff @(posedge clock) begin
        if (reset) begin
            msip     <= 1'b0;
            mtime    <= 64'd0;
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            mtip     <= 1'b0;
        end else begin
            mtime <= mtime_next;
            mtip  <= (mtime >= mtimecmp);
            if (wr && sel_msip && req.wstrb[0]) begin
                msip <= req.wdata[0];
            end
            if (wr && sel_cmp_lo) begin
                mtimecmp[31:0] <= byte_merge(mtimecmp[31:0], req.wdata, req.wstrb);
            end
            if (wr && sel_cmp_hi) begin
                mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], req.wdata, req.wstrb);
            end
        end
    end

    assign bus.mem_ready = ready;
    assign bus.mem_rdata = rdata;
    assign clint_msip    = msip;
    assign clint_mtip    = mtip;
    assign clint_mtime   = mtime;

endmodule
